// File: rtl/bcd_addsub_serial.sv
// Digit-serial DIGITS-digit BCD adder/subtractor, least-significant digit first, one shared digit slice.
// Optional macro BCD_SIGNMAG_EN: a negative subtract result is re-negated into magnitude form with neg=1.
module bcd_addsub_serial #(
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  mode,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   result,
   output logic                  carry,
   output logic                  err,
   output logic                  neg
);

   localparam int unsigned W        = 4 * DIGITS;
   localparam int unsigned IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

`ifdef BCD_SIGNMAG_EN
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_DONE   = 2'd2,
      S_NEGATE = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_DONE   = 2'd2
   } state_t;
`endif

   state_t             state_q, state_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic               mode_q, mode_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               c_q, c_d;
   logic               bad_q, bad_d;
   logic [W-1:0]       result_q, result_d;
   logic               carry_q, carry_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
`ifdef BCD_SIGNMAG_EN
   logic               neg_q, neg_d;
`endif

   logic [3:0]         slice_x;
   logic [3:0]         slice_y;
   logic               slice_sub;
   logic [4:0]         slice_sum;
   logic [3:0]         slice_digit;
   logic               slice_cout;

   function automatic logic [3:0] digit_at(input logic [W-1:0] v, input logic [IDX_W-1:0] i);
      logic [3:0] r;
      r = 4'd0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (IDX_W'(k) == i) r = v[4*k +: 4];
      end
      return r;
   endfunction

   function automatic logic [W-1:0] put_digit(input logic [W-1:0] v, input logic [IDX_W-1:0] i,
                                              input logic [3:0] d);
      logic [W-1:0] r;
      r = v;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (IDX_W'(k) == i) r[4*k +: 4] = d;
      end
      return r;
   endfunction

   function automatic logic has_bad_digit(input logic [W-1:0] v);
      logic r;
      r = 1'b0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (v[4*k +: 4] > 4'd9) r = 1'b1;
      end
      return r;
   endfunction

   // Shared digit slice; NEGATE reuses it as 0 - result digit.
   always_comb begin
      slice_x   = digit_at(a_q, idx_q);
      slice_y   = digit_at(b_q, idx_q);
      slice_sub = mode_q;
`ifdef BCD_SIGNMAG_EN
      if (state_q == S_NEGATE) begin
         slice_x   = 4'd0;
         slice_y   = digit_at(result_q, idx_q);
         slice_sub = 1'b1;
      end
`endif
      slice_digit = 4'd0;
      slice_cout  = 1'b0;
      if (slice_sub) begin
         // 5-bit two's complement difference always fits: range -16..15.
         slice_sum = {1'b0, slice_x} - {1'b0, slice_y} - {4'd0, c_q};
         if (slice_sum[4]) begin
            slice_digit = 4'(slice_sum + 5'd10);
            slice_cout  = 1'b1;
         end else begin
            slice_digit = slice_sum[3:0];
         end
      end else begin
         slice_sum = {1'b0, slice_x} + {1'b0, slice_y} + {4'd0, c_q};
         if (slice_sum > 5'd9) begin
            slice_digit = 4'(slice_sum - 5'd10);
            slice_cout  = 1'b1;
         end else begin
            slice_digit = slice_sum[3:0];
         end
      end
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      mode_d   = mode_q;
      idx_d    = idx_q;
      c_d      = c_q;
      bad_d    = bad_q;
      result_d = result_q;
      carry_d  = carry_q;
      err_d    = err_q;
`ifdef BCD_SIGNMAG_EN
      neg_d    = neg_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d      = a;
               b_d      = b;
               mode_d   = mode;
               bad_d    = has_bad_digit(a) | has_bad_digit(b);
               idx_d    = '0;
               c_d      = 1'b0;
               result_d = '0;
               carry_d  = 1'b0;
               err_d    = 1'b0;
`ifdef BCD_SIGNMAG_EN
               neg_d    = 1'b0;
`endif
               state_d  = S_RUN;
            end
         end

         S_RUN: begin
            result_d = put_digit(result_q, idx_q, slice_digit);
            c_d      = slice_cout;
            idx_d    = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               c_d     = 1'b0;
               err_d   = bad_q;
               state_d = S_DONE;
               if (bad_q) begin
                  result_d = '0;
                  carry_d  = 1'b0;
               end else begin
                  carry_d  = slice_cout;
`ifdef BCD_SIGNMAG_EN
                  if (mode_q && slice_cout) begin
                     carry_d = 1'b0;
                     state_d = S_NEGATE;
                  end
`endif
               end
            end
         end

`ifdef BCD_SIGNMAG_EN
         S_NEGATE: begin
            result_d = put_digit(result_q, idx_q, slice_digit);
            c_d      = slice_cout;
            idx_d    = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               c_d     = 1'b0;
               carry_d = 1'b1;
               neg_d   = 1'b1;
               state_d = S_DONE;
            end
         end
`endif

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         mode_q   <= 1'b0;
         idx_q    <= '0;
         c_q      <= 1'b0;
         bad_q    <= 1'b0;
         result_q <= '0;
         carry_q  <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef BCD_SIGNMAG_EN
         neg_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         mode_q   <= mode_d;
         idx_q    <= idx_d;
         c_q      <= c_d;
         bad_q    <= bad_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef BCD_SIGNMAG_EN
         neg_q    <= neg_d;
`endif
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign carry  = carry_q;
   assign err    = err_q;
`ifdef BCD_SIGNMAG_EN
   assign neg    = neg_q;
`else
   assign neg    = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Scoreboard bench for bcd_addsub_serial (DIGITS=4): expected results from an integer decimal model.
module tb_bcd_addsub_serial;

   localparam int unsigned DIGITS = 4;
   localparam int unsigned W      = 4 * DIGITS;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         mode  = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry;
   logic         err;
   logic         neg;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [W-1:0] res;
      logic         carry;
      logic         err;
      logic         neg;
      int           lat;
   } exp_t;

   exp_t sb_q[$];

   bcd_addsub_serial #(.DIGITS(DIGITS)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .mode   (mode),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .carry  (carry),
      .err    (err),
      .neg    (neg)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int bcd2int(input logic [W-1:0] v);
      int r;
      logic [3:0] d;
      r = 0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         d = v[4*i +: 4];
         r = r * 10 + int'(d);
      end
      return r;
   endfunction

   function automatic logic [W-1:0] int2bcd(input int v);
      logic [W-1:0] r;
      int t;
      r = '0;
      t = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic exp_t model(input logic m, input logic [W-1:0] av, input logic [W-1:0] bv);
      exp_t e;
      int   x, y, s, md;
      bit   bad;
      md  = 1;
      bad = 0;
      for (int i = 0; i < DIGITS; i++) begin
         md = md * 10;
         if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) bad = 1;
      end
      e.neg = 1'b0;
      e.lat = DIGITS;
      e.err = bad;
      if (bad) begin
         e.res   = '0;
         e.carry = 1'b0;
         return e;
      end
      x = bcd2int(av);
      y = bcd2int(bv);
      if (!m) begin
         s       = x + y;
         e.carry = (s >= md);
         e.res   = int2bcd(s % md);
      end else begin
         s = x - y;
         if (s < 0) begin
            e.carry = 1'b1;
`ifdef BCD_SIGNMAG_EN
            e.res = int2bcd(-s);
            e.neg = 1'b1;
            e.lat = 2 * DIGITS;
`else
            e.res = int2bcd(s + md);
`endif
         end else begin
            e.carry = 1'b0;
            e.res   = int2bcd(s);
         end
      end
      return e;
   endfunction

   function automatic logic [W-1:0] rand_bcd();
      logic [W-1:0] r;
      for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
      return r;
   endfunction

   // One operation: push expectation, drive, wait for done, pop and compare.
   task automatic run_op(input string name, input logic m, input logic [W-1:0] av, input logic [W-1:0] bv);
      exp_t e;
      int   lat;
      bit   seen;
      sb_q.push_back(model(m, av, bv));
      @(negedge clk);
      start = 1'b1;
      mode  = m;
      a     = av;
      b     = bv;
      @(posedge clk);
      #1;
      start = 1'b0;
      n_vec++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
      end
      seen = 0;
      lat  = 0;
      for (int c = 1; c <= 3 * DIGITS + 4 && !seen; c++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            seen = 1;
            lat  = c;
         end
      end
      e = sb_q.pop_front();
      n_vec++;
      if (!seen) begin
         n_bad++;
         $display("FAIL %s done_timeout: got no done, want done after %0d cycles", name, e.lat);
         return;
      end
      n_vec++;
      if (lat !== e.lat) begin
         n_bad++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, e.lat);
      end
      n_vec++;
      if (result !== e.res) begin
         n_bad++;
         $display("FAIL %s result: got %h want %h", name, result, e.res);
      end
      n_vec++;
      if (carry !== e.carry) begin
         n_bad++;
         $display("FAIL %s carry: got %b want %b", name, carry, e.carry);
      end
      n_vec++;
      if (err !== e.err) begin
         n_bad++;
         $display("FAIL %s err: got %b want %b", name, err, e.err);
      end
      n_vec++;
      if (neg !== e.neg) begin
         n_bad++;
         $display("FAIL %s neg: got %b want %b", name, neg, e.neg);
      end
      n_vec++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL %s busy_at_done: got %b want 1", name, busy);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, done, busy);
      end
      n_vec++;
      if (result !== e.res) begin
         n_bad++;
         $display("FAIL %s result_hold: got %h want %h", name, result, e.res);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b1;
      a     = 16'h1234;
      b     = 16'h1111;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got busy=%b done=%b want 0 0", busy, done);
      end
      n_vec++;
      if (result !== '0 || carry !== 1'b0 || err !== 1'b0 || neg !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_data: got result=%h carry=%b err=%b neg=%b want 0", result, carry, err, neg);
      end
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      run_op("add_1234_5678", 1'b0, 16'h1234, 16'h5678);
      run_op("add_9999_0001", 1'b0, 16'h9999, 16'h0001);
      run_op("add_0000_0000", 1'b0, 16'h0000, 16'h0000);
      run_op("add_5005_4995", 1'b0, 16'h5005, 16'h4995);
   endtask

   task automatic test_sub();
      run_op("sub_0005_0003", 1'b1, 16'h0005, 16'h0003);
      run_op("sub_0003_0005", 1'b1, 16'h0003, 16'h0005);
      run_op("sub_1000_0001", 1'b1, 16'h1000, 16'h0001);
      run_op("sub_0000_9999", 1'b1, 16'h0000, 16'h9999);
      run_op("sub_4321_4321", 1'b1, 16'h4321, 16'h4321);
   endtask

   task automatic test_err();
      run_op("err_00A0_0001", 1'b0, 16'h00A0, 16'h0001);
      run_op("err_sub_b_F000", 1'b1, 16'h0005, 16'hF000);
   endtask

   // Starts during RUN and during DONE must be dropped; operand changes after accept are harmless.
   task automatic test_ignore_start();
      exp_t e;
      int   lat;
      int   extra;
      bit   seen;
      sb_q.push_back(model(1'b0, 16'h1234, 16'h5678));
      @(negedge clk);
      start = 1'b1;
      mode  = 1'b0;
      a     = 16'h1234;
      b     = 16'h5678;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      mode  = 1'b1;
      a     = 16'h9999;
      b     = 16'h9999;
      @(posedge clk);
      #1;
      start = 1'b0;
      seen  = 0;
      lat   = 2;
      for (int c = 3; c <= 3 * DIGITS + 4 && !seen; c++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            seen = 1;
            lat  = c;
         end
      end
      e = sb_q.pop_front();
      n_vec++;
      if (!seen || lat !== e.lat) begin
         n_bad++;
         $display("FAIL ignore_latency: got seen=%0d lat=%0d want lat=%0d", seen, lat, e.lat);
      end
      n_vec++;
      if (result !== e.res || carry !== e.carry) begin
         n_bad++;
         $display("FAIL ignore_result: got %h/%b want %h/%b", result, carry, e.res, e.carry);
      end
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL ignore_in_done: got busy=%b done=%b want 0 0", busy, done);
      end
      extra = 0;
      repeat (2 * DIGITS + 2) begin
         @(posedge clk);
         #1;
         if (busy === 1'b1 || done === 1'b1) extra++;
      end
      n_vec++;
      if (extra !== 0) begin
         n_bad++;
         $display("FAIL ignore_not_queued: got %0d busy/done cycles want 0", extra);
      end
   endtask

   task automatic test_reset_abort();
      int activity;
      @(negedge clk);
      start = 1'b1;
      mode  = 1'b0;
      a     = 16'h1234;
      b     = 16'h5678;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_ctrl: got busy=%b done=%b want 0 0", busy, done);
      end
      n_vec++;
      if (result !== '0 || carry !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_data: got result=%h carry=%b want 0000 0", result, carry);
      end
      @(negedge clk);
      rst_n = 1'b1;
      activity = 0;
      repeat (2 * DIGITS + 4) begin
         @(posedge clk);
         #1;
         if (done === 1'b1 || busy === 1'b1) activity++;
      end
      n_vec++;
      if (activity !== 0) begin
         n_bad++;
         $display("FAIL abort_no_done: got %0d busy/done cycles want 0", activity);
      end
      run_op("after_abort", 1'b0, 16'h0456, 16'h0123);
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] ra, rb;
      logic         rm;
      for (int i = 0; i < 8; i++) begin
         ra = rand_bcd();
         rb = rand_bcd();
         rm = 1'($urandom_range(0, 1));
         run_op($sformatf("b2b_%0d", i), rm, ra, rb);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_err();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/bcd_addsub_serial.md
Name: bcd_addsub_serial

Overview:
- Digit-serial, parametrised N-digit BCD adder/subtractor for the stopwatch datapath, e.g. lap-time differences and preset arithmetic.
- Generalises the existing single-digit BCD add/subtract logic to DIGITS digits with one shared digit slice.
- Processes one BCD digit per clock, least-significant digit first.
- Start/busy/done handshake; reports final carry/borrow and invalid-digit errors.

Parameters:
- DIGITS, 4, number of BCD digits per operand and result (legal: 1 to 8).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- mode  in  1  0 = add (a+b), 1 = subtract (a-b); latched at accept.
- a  in  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0]; latched at accept.
- b  in  4*DIGITS  operand B, same packing; latched at accept.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse; result, carry, err and neg valid while high.
- result  out  4*DIGITS  packed BCD result; held after done until the next accept.
- carry  out  1  add: decimal overflow; subtract: final borrow (a<b).
- err  out  1  an operand digit was greater than 9.
- neg  out  1  result is a negative magnitude (optional feature only, else constant 0).

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE.
  - busy, done, carry, err and neg all 0.
  - result all 0; digit index 0; internal carry/borrow 0.
  - Reset mid-operation aborts immediately; no done pulse.
- States: IDLE, RUN, DONE (and NEGATE with the optional feature).
- IDLE:
  - start=1 at edge E0 → latch a, b, mode; clear result, carry, err and neg; index=0; carry-in 0; go to RUN.
  - If any digit of a or b is greater than 9, err is flagged internally.
- RUN, edge E(k+1), k = 0..DIGITS-1, writes digit k:
  - Add: s = a_k + b_k + c. If s > 9 then digit = s-10 and c = 1, else digit = s and c = 0.
  - Sub: d = a_k - b_k - c (signed 5-bit). If d < 0 then digit = d+10 and c = 1, else digit = d and c = 0.
  - Arithmetic uses 5-bit intermediates; no wrap beyond a single digit.
  - After digit DIGITS-1 (edge E(DIGITS)) go to DONE.
  - At that edge, carry = final c and err is registered.
  - If err=1: result is forced to all 0 and carry to 0.
- DONE:
  - done=1 for exactly one cycle; next edge returns to IDLE.
- Latency: done is high between E(DIGITS) and E(DIGITS+1); busy is high between E0 and E(DIGITS+1).
- Throughput: a new start is accepted at E(DIGITS+1) at the earliest, i.e. one operation per DIGITS+1 cycles.
- start while busy (including the DONE cycle) is ignored, not queued.
- mode, a and b changing after accept have no effect.
- Subtract with borrow, feature off: result is the ten's complement modulo 10^DIGITS, carry=1, neg=0.
- Add overflow: result is the sum modulo 10^DIGITS, carry=1.

Optional Feature:
- Macro BCD_SIGNMAG_EN.
- Defined: when mode=1, the final borrow is 1 and err=0, RUN goes to NEGATE instead of DONE.
  - NEGATE runs DIGITS more cycles, computing 0 - result digit-serially with the same subtract slice.
  - Result becomes the magnitude |a-b|; then DONE with neg=1 and carry=1.
  - done then pulses between E(2*DIGITS) and E(2*DIGITS+1).
  - All other cases behave as with the feature off.
- Undefined: no NEGATE state; neg is tied to 0; latency is always DIGITS+1.

Test Plan (DIGITS=4):
- Add 1234+5678, start at E0 → done at E4 only; result 6912, carry 0, err 0; busy high from E0 to E5.
- Add 9999+0001 → result 0000, carry 1; add 0000+0000 → result 0000, carry 0.
- Sub 0005-0003 → 0002, carry 0.
- Sub 0003-0005:
  - Macro off → 9998, carry 1, neg 0, done at E4.
  - Macro on → 0002, carry 1, neg 1, done at E8.
- a=00A0, b=0001, add → err 1, result 0000, carry 0, done at E4.
- start pulsed at E2 and during the DONE cycle → ignored, single done; rst_n low after E2 → busy/result/done 0 immediately, no done; the next start then completes normally.
